frame_rx_parser: RTL and testbench

//  Byte-serial framed receiver, successor of the fixed header+2-byte receiver. Samples DATA_W-bit

---
 rtl/frame_rx_pkg.sv | 27 ++
 rtl/frame_rx_parser_timeout.sv | 34 +++
 rtl/frame_rx_parser.sv | 204 ++++++++++++++++++++
 tb/tb_frame_rx_parser.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_rx_pkg.sv
// Shared types for the framed receiver: FSM state codes and error codes,
// used by the parser, the command decoder and the bench.
package frame_rx_pkg;

    localparam int STATE_W = 2;

    // Legacy-compatible state constants; the enum below carries the same values.
    localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
    localparam logic [STATE_W-1:0] ST_PAYLOAD = 2'd1;
    localparam logic [STATE_W-1:0] ST_CHECK   = 2'd2;
    localparam logic [STATE_W-1:0] ST_OUT     = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = ST_IDLE,
        PAYLOAD = ST_PAYLOAD,
        CHECK   = ST_CHECK,
        OUT     = ST_OUT
    } rx_state_e;

    typedef enum logic [1:0] {
        ERR_NONE = 2'd0,
        ERR_HDR  = 2'd1,
        ERR_CHK  = 2'd2,
        ERR_TMO  = 2'd3
    } rx_err_e;

endpackage

// File: rtl/frame_rx_parser_timeout.sv
// Idle-cycle watchdog for the frame receiver. Counts enabled cycles since the
// last clear and flags expiry on the cycle that would bring the count to LIMIT.
module frame_rx_timeout #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int            CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_r;

    // Expiry is the LIMIT-th consecutive enabled cycle; a clear in the same cycle wins.
    assign expire = en && !clr && (cnt_r == LAST);

    // Idle counter: cleared by a sampled word, inactive states or expiry, else counts enabled cycles.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (clr || expire) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

endmodule

// File: rtl/frame_rx_parser.sv
// Framed word receiver: HEADER, PAYLOAD_WORDS payload words, optional XOR
// checksum. Assembled payload is presented on a valid/ready port; errors are
// reported as one-cycle pulses with a sticky code.
module frame_rx_parser
    import frame_rx_pkg::*;
#(
    parameter int                DATA_W        = 8,
    parameter int                PAYLOAD_WORDS = 2,
    parameter logic [DATA_W-1:0] HEADER        = 8'hCA,
    parameter bit                CHK_EN        = 1'b1,
    parameter int                TIMEOUT       = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              cs,
    input  logic [DATA_W-1:0]                 d_in,
    output logic                              ack,
    output logic                              err,
    output logic [1:0]                        err_code,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DATA_W*PAYLOAD_WORDS-1:0]   d_out,
    output logic                              busy
);

    localparam int                OUT_W     = DATA_W * PAYLOAD_WORDS;
    localparam int                CNT_W     = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
    localparam logic [CNT_W-1:0]  LAST_WORD = CNT_W'(PAYLOAD_WORDS - 1);

    logic [STATE_W-1:0] state_r,    state_n;
    logic [CNT_W-1:0]   cnt_r,      cnt_n;
    logic [DATA_W-1:0]  acc_r,      acc_n;
    logic [OUT_W-1:0]   shift_r,    shift_n;
    logic               ack_r,      ack_n;
    logic               err_r,      err_n;
    logic [1:0]         err_code_r, err_code_n;
    logic               valid_r,    valid_n;
    logic [OUT_W-1:0]   d_out_r,    d_out_n;

    logic [OUT_W-1:0]   shift_next_s;
    logic               tmo_active_s;
    logic               tmo_clr_s;
    logic               tmo_en_s;
    logic               tmo_expire_s;

    // New word enters at the LSB end so the first payload word ends up in the MSBs.
    generate
        if (PAYLOAD_WORDS > 1) begin : g_shift_multi
            assign shift_next_s = {shift_r[OUT_W-DATA_W-1:0], d_in};
        end else begin : g_shift_single
            assign shift_next_s = d_in;
        end
    endgenerate

    // The watchdog only runs while a frame is being collected.
    assign tmo_active_s = (state_r == ST_PAYLOAD) || (state_r == ST_CHECK);
    assign tmo_clr_s    = !tmo_active_s || !cs;
    assign tmo_en_s     = tmo_active_s && cs;

    frame_rx_timeout #(
        .LIMIT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmo_clr_s),
        .en     (tmo_en_s),
        .expire (tmo_expire_s)
    );

    // Next-state logic for the frame FSM, payload shifter, checksum and output port.
    always_comb begin
        state_n    = state_r;
        cnt_n      = cnt_r;
        acc_n      = acc_r;
        shift_n    = shift_r;
        ack_n      = 1'b0;
        err_n      = 1'b0;
        err_code_n = err_code_r;
        valid_n    = valid_r;
        d_out_n    = d_out_r;

        case (state_r)
            ST_IDLE: begin
                if (!cs) begin
                    if (d_in == HEADER) begin
                        ack_n   = 1'b1;
                        acc_n   = HEADER;
                        cnt_n   = '0;
                        shift_n = '0;
                        state_n = ST_PAYLOAD;
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = ERR_HDR;
                    end
                end else begin
                    state_n = ST_IDLE;
                end
            end

            ST_PAYLOAD: begin
                if (!cs) begin
                    ack_n   = 1'b1;
                    shift_n = shift_next_s;
                    acc_n   = acc_r ^ d_in;
                    if (cnt_r == LAST_WORD) begin
                        if (CHK_EN) begin
                            state_n = ST_CHECK;
                        end else begin
                            state_n = ST_OUT;
                            valid_n = 1'b1;
                            d_out_n = shift_next_s;
                        end
                    end else begin
                        cnt_n = cnt_r + CNT_W'(1);
                    end
                end else if (tmo_expire_s) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_TMO;
                    state_n    = ST_IDLE;
                end else begin
                    state_n = ST_PAYLOAD;
                end
            end

            ST_CHECK: begin
                if (!cs) begin
                    if (d_in == acc_r) begin
                        ack_n   = 1'b1;
                        state_n = ST_OUT;
                        valid_n = 1'b1;
                        d_out_n = shift_r;
                    end else begin
                        // Bad checksum: the collected payload is simply abandoned.
                        err_n      = 1'b1;
                        err_code_n = ERR_CHK;
                        state_n    = ST_IDLE;
                    end
                end else if (tmo_expire_s) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_TMO;
                    state_n    = ST_IDLE;
                end else begin
                    state_n = ST_CHECK;
                end
            end

            ST_OUT: begin
                // A word arriving while the payload is still held is an overrun; it is dropped.
                if (!cs) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_TMO;
                end else begin
                    err_n = 1'b0;
                end
                if (valid_r && out_ready) begin
                    valid_n = 1'b0;
                    d_out_n = '0;
                    state_n = ST_IDLE;
                end else begin
                    state_n = ST_OUT;
                end
            end

            default: begin
                state_n = ST_IDLE;
                valid_n = 1'b0;
                d_out_n = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            cnt_r      <= '0;
            acc_r      <= '0;
            shift_r    <= '0;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            valid_r    <= 1'b0;
            d_out_r    <= '0;
        end else begin
            state_r    <= state_n;
            cnt_r      <= cnt_n;
            acc_r      <= acc_n;
            shift_r    <= shift_n;
            ack_r      <= ack_n;
            err_r      <= err_n;
            err_code_r <= err_code_n;
            valid_r    <= valid_n;
            d_out_r    <= d_out_n;
        end
    end

    assign ack       = ack_r;
    assign err       = err_r;
    assign err_code  = err_code_r;
    assign out_valid = valid_r;
    assign d_out     = d_out_r;
    assign busy      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_frame_rx_parser.sv
// Bench for frame_rx_parser: a directed vector table, hand-written multi-cycle
// sequences, a second instance with CHK_EN=0/PAYLOAD_WORDS=4, and randomized
// traffic checked against a word-queue reference model.
module tb_frame_rx_parser;
    import frame_rx_pkg::*;

    localparam int          P   = 2;
    localparam int          TMO = 16;
    localparam logic [7:0]  HDR = 8'hCA;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, cs, out_ready;
    logic [7:0]  d_in;
    logic        ack, err, out_valid, busy;
    logic [1:0]  err_code;
    logic [15:0] d_out;

    logic        cs_b, rdy_b;
    logic [7:0]  d_b;
    logic        ack_b, err_b, valid_b, busy_b;
    logic [1:0]  code_b;
    logic [31:0] dout_b;

    frame_rx_parser dut_a (
        .clk(clk), .rst(rst), .cs(cs), .d_in(d_in), .ack(ack), .err(err),
        .err_code(err_code), .out_valid(out_valid), .out_ready(out_ready),
        .d_out(d_out), .busy(busy)
    );

    frame_rx_parser #(.DATA_W(8), .PAYLOAD_WORDS(4), .HEADER(8'hCA), .CHK_EN(1'b0), .TIMEOUT(16)) dut_b (
        .clk(clk), .rst(rst), .cs(cs_b), .d_in(d_b), .ack(ack_b), .err(err_b),
        .err_code(code_b), .out_valid(valid_b), .out_ready(rdy_b),
        .d_out(dout_b), .busy(busy_b)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: frame in progress as a queue of received payload words.
    bit         m_in_frame = 1'b0;
    bit         m_have_out = 1'b0;
    logic [7:0] m_words[$];
    int         m_idle = 0;
    logic [15:0] m_out = 16'h0;
    logic [1:0] m_code = 2'd0;
    bit         m_ack = 1'b0, m_err = 1'b0;

    typedef struct {
        logic        c;
        logic [7:0]  d;
        logic        rdy;
        logic        a;
        logic        e;
        logic [1:0]  code;
        logic        v;
        logic        b;
        logic [15:0] dout;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic c, logic [7:0] d, logic rdy, logic a, logic e,
                                logic [1:0] code, logic v, logic b, logic [15:0] dout);
        vec_t t;
        t.c = c; t.d = d; t.rdy = rdy; t.a = a; t.e = e;
        t.code = code; t.v = v; t.b = b; t.dout = dout;
        return t;
    endfunction

    function automatic logic [7:0] model_chk();
        logic [7:0] x;
        x = HDR;
        foreach (m_words[i]) x = x ^ m_words[i];
        return x;
    endfunction

    task automatic model_step(input logic r, input logic c, input logic [7:0] d, input logic rdy);
        m_ack = 1'b0;
        m_err = 1'b0;
        if (!r) begin
            m_in_frame = 1'b0; m_have_out = 1'b0; m_words.delete();
            m_idle = 0; m_out = 16'h0; m_code = 2'd0;
        end else if (m_have_out) begin
            if (!c) begin m_err = 1'b1; m_code = 2'd3; end
            if (rdy) m_have_out = 1'b0;
        end else if (m_in_frame) begin
            if (!c) begin
                m_idle = 0;
                if (m_words.size() < P) begin
                    m_words.push_back(d);
                    m_ack = 1'b1;
                end else if (d == model_chk()) begin
                    m_ack = 1'b1;
                    m_out = 16'h0;
                    foreach (m_words[i]) m_out = (m_out << 8) | {8'h00, m_words[i]};
                    m_in_frame = 1'b0;
                    m_have_out = 1'b1;
                end else begin
                    m_err = 1'b1; m_code = 2'd2; m_in_frame = 1'b0;
                end
            end else begin
                m_idle++;
                if (m_idle >= TMO) begin m_err = 1'b1; m_code = 2'd3; m_in_frame = 1'b0; end
            end
        end else if (!c) begin
            if (d == HDR) begin
                m_in_frame = 1'b1; m_words.delete(); m_idle = 0; m_ack = 1'b1;
            end else begin
                m_err = 1'b1; m_code = 2'd1;
            end
        end
    endtask

    function automatic logic [21:0] pack_a();
        return {ack, err, err_code, out_valid, busy, d_out};
    endfunction

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Apply one cycle to instance A (model follows), outputs sampled 1 ns after the edge.
    task automatic step(input logic r, input logic c, input logic [7:0] d, input logic rdy);
        rst = r; cs = c; d_in = d; out_ready = rdy;
        model_step(r, c, d, rdy);
        @(posedge clk);
        #1;
    endtask

    task automatic step_b(input logic c, input logic [7:0] d, input logic rdy);
        cs_b = c; d_b = d; rdy_b = rdy;
        step(1'b1, 1'b1, 8'h00, 1'b0);
    endtask

    initial begin
        bit early;
        int burst;
        logic c;
        logic [7:0] d;
        logic r;
        logic rdy;

        rst = 1'b0; cs = 1'b1; d_in = 8'h00; out_ready = 1'b0;
        cs_b = 1'b1; d_b = 8'h00; rdy_b = 1'b0;

        tbl[0]  = mk(1'b0, 8'hCA, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000);
        tbl[1]  = mk(1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000);
        tbl[2]  = mk(1'b0, 8'h34, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 16'h0000);
        tbl[3]  = mk(1'b0, 8'hEC, 1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 16'h1234);
        tbl[4]  = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 16'h0000);
        tbl[5]  = mk(1'b0, 8'h55, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 16'h0000);
        tbl[6]  = mk(1'b0, 8'hCA, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000);
        tbl[7]  = mk(1'b0, 8'hAB, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000);
        tbl[8]  = mk(1'b0, 8'hCD, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000);
        tbl[9]  = mk(1'b0, 8'hAC, 1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 16'hABCD);
        tbl[10] = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 16'h0000);
        tbl[11] = mk(1'b0, 8'hCA, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000);
        tbl[12] = mk(1'b0, 8'h12, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000);
        tbl[13] = mk(1'b0, 8'h34, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 16'h0000);
        tbl[14] = mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 16'h0000);
        tbl[15] = mk(1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 16'h0000);

        // Reset state of both instances
        step(1'b0, 1'b1, 8'h00, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("reset_a", 40'(pack_a()), 40'h0);
        chk("reset_b", {ack_b, err_b, code_b, valid_b, busy_b, dout_b}, 40'h0);

        // Directed table: good frame, bad header then good frame, bad checksum
        for (int i = 0; i < 16; i++) begin
            step(1'b1, tbl[i].c, tbl[i].d, tbl[i].rdy);
            chk($sformatf("table_%0d", i), 40'(pack_a()),
                40'({tbl[i].a, tbl[i].e, tbl[i].code, tbl[i].v, tbl[i].b, tbl[i].dout}));
        end

        // Timeout: 16 idle cycles mid-frame abort, 15 do not
        step(1'b1, 1'b0, HDR, 1'b0);
        step(1'b1, 1'b0, 8'h12, 1'b0);
        early = 1'b0;
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b1, 8'h00, 1'b0);
            if (err || !busy) early = 1'b1;
        end
        chk("tmo_no_early", 40'(early), 40'h0);
        step(1'b1, 1'b1, 8'h00, 1'b0);
        chk("tmo_expire", 40'({err, err_code, busy}), 40'({1'b1, 2'd3, 1'b0}));
        step(1'b1, 1'b0, HDR, 1'b0);
        step(1'b1, 1'b0, 8'h12, 1'b0);
        for (int i = 0; i < 15; i++) step(1'b1, 1'b1, 8'h00, 1'b0);
        chk("tmo_15_busy", 40'({err, busy}), 40'({1'b0, 1'b1}));
        step(1'b1, 1'b0, 8'h34, 1'b0);
        chk("tmo_15_ack", 40'({ack, err, busy}), 40'({1'b1, 1'b0, 1'b1}));
        step(1'b1, 1'b0, 8'hEC, 1'b0);
        chk("tmo_15_done", 40'({ack, out_valid, d_out}), 40'({1'b1, 1'b1, 16'h1234}));
        step(1'b1, 1'b1, 8'h00, 1'b1);
        chk("tmo_15_hs", 40'({out_valid, busy, d_out}), 40'h0);

        // Overrun while output is held, then handshake and back-to-back header
        step(1'b1, 1'b0, 8'h55, 1'b0);
        chk("hdr_err", 40'({err, err_code}), 40'({1'b1, 2'd1}));
        step(1'b1, 1'b0, HDR, 1'b0);
        step(1'b1, 1'b0, 8'h12, 1'b0);
        step(1'b1, 1'b0, 8'h34, 1'b0);
        step(1'b1, 1'b0, 8'hEC, 1'b0);
        chk("hold_valid", 40'({out_valid, d_out}), 40'({1'b1, 16'h1234}));
        for (int i = 0; i < 5; i++) begin
            step(1'b1, (i == 2) ? 1'b0 : 1'b1, 8'h77, 1'b0);
            chk($sformatf("hold_%0d", i), 40'({err, err_code, out_valid, d_out}),
                40'({(i == 2), (i >= 2) ? 2'd3 : 2'd1, 1'b1, 16'h1234}));
        end
        step(1'b1, 1'b1, 8'h00, 1'b1);
        chk("hold_hs", 40'({out_valid, d_out, busy}), 40'h0);
        step(1'b1, 1'b0, HDR, 1'b0);
        chk("b2b_hdr", 40'({ack, err, busy}), 40'({1'b1, 1'b0, 1'b1}));

        // Reset mid-frame discards the partial frame and clears the sticky code
        step(1'b1, 1'b0, 8'h12, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("rst_mid", 40'(pack_a()), 40'h0);
        step(1'b1, 1'b0, HDR, 1'b0);
        step(1'b1, 1'b0, 8'h56, 1'b0);
        step(1'b1, 1'b0, 8'h78, 1'b0);
        step(1'b1, 1'b0, 8'hE4, 1'b0);
        chk("rst_after", 40'(pack_a()), 40'({1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 16'h5678}));
        step(1'b1, 1'b1, 8'h00, 1'b1);
        chk("rst_after_hs", 40'({out_valid, busy}), 40'h0);

        // Instance without checksum, four payload words
        step_b(1'b0, HDR, 1'b0);
        step_b(1'b0, 8'h01, 1'b0);
        step_b(1'b0, 8'h02, 1'b0);
        step_b(1'b0, 8'h03, 1'b0);
        chk("b_mid", {ack_b, err_b, valid_b, busy_b}, 40'({1'b1, 1'b0, 1'b0, 1'b1}));
        step_b(1'b0, 8'h04, 1'b0);
        chk("b_done", {ack_b, valid_b, dout_b}, 40'({1'b1, 1'b1, 32'h01020304}));
        step_b(1'b0, 8'h99, 1'b0);
        chk("b_overrun", {err_b, code_b, valid_b, dout_b}, 40'({1'b1, 2'd3, 1'b1, 32'h01020304}));
        step_b(1'b1, 8'h00, 1'b1);
        chk("b_hs", {valid_b, busy_b, dout_b}, 40'h0);
        cs_b = 1'b1; rdy_b = 1'b0;

        // Randomized traffic against the reference model
        burst = 0;
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) != 0);
            if (burst > 0) begin
                c = 1'b1;
                burst--;
            end else if ($urandom_range(0, 49) == 0) begin
                c = 1'b1;
                burst = 16 + $urandom_range(0, 1);
            end else begin
                c = ($urandom_range(0, 9) < 3);
            end
            if (m_in_frame && m_words.size() == P && $urandom_range(0, 1) == 1)
                d = model_chk();
            else if ($urandom_range(0, 2) == 0)
                d = HDR;
            else
                d = 8'($urandom);
            rdy = ($urandom_range(0, 2) != 0);
            step(r, c, d, rdy);
            chk($sformatf("rand_%0d", i), 40'(pack_a()),
                40'({m_ack, m_err, m_code, m_have_out, (m_in_frame || m_have_out),
                     m_have_out ? m_out : 16'h0}));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
